// File: rtl/axi_fsrc_pkg.sv
// Shared types and default constants for the FSRC sequence-capture logic.
package axi_fsrc_pkg;

  localparam int CTRL_WIDTH_DEF    = 40;
  localparam int COUNTER_WIDTH_DEF = 4;
  localparam int NUM_TRIG_DEF      = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SYSREF,
    ST_COUNT,
    ST_DONE
  } fsrc_state_e;

endpackage

// File: rtl/fsrc_edge_detect.sv
// One-register rising-edge detector; rise is combinational from the live input.
module fsrc_edge_detect #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] din_q;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) din_q <= '0;
    else       din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/rx_fsrc_seq_capture.sv
// Captures FSRC trigger events, time-stamped relative to the last sysref edge,
// into a single-entry valid/ready record with a sticky overflow flag.
module rx_fsrc_seq_capture
  import axi_fsrc_pkg::*;
#(
  parameter int CTRL_WIDTH    = CTRL_WIDTH_DEF,
  parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEF,
  parameter int NUM_TRIG      = NUM_TRIG_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     sysref,
  input  logic [NUM_TRIG-1:0]      trig_in,
  input  logic                     data_start,
  input  logic [CTRL_WIDTH-1:0]    ctrl_in,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [NUM_TRIG-1:0]      ev_trig,
  output logic [COUNTER_WIDTH-1:0] ev_cnt,
  output logic [CTRL_WIDTH-1:0]    ev_ctrl,
  output logic                     overflow,
  output logic                     busy,
  output logic                     done
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = 1;

  logic                     sysref_rise;
  logic                     data_start_rise;
  logic [NUM_TRIG-1:0]      trig_rise;
  fsrc_state_e              state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_now;
  logic                     ev_hit;
  logic                     arm;

  fsrc_edge_detect #(.WIDTH(1)) u_sysref_edge (
    .clk(clk), .reset(reset), .din(sysref), .rise(sysref_rise)
  );

  fsrc_edge_detect #(.WIDTH(NUM_TRIG)) u_trig_edge (
    .clk(clk), .reset(reset), .din(trig_in), .rise(trig_rise)
  );

  fsrc_edge_detect #(.WIDTH(1)) u_data_start_edge (
    .clk(clk), .reset(reset), .din(data_start), .rise(data_start_rise)
  );

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:        state_d = ST_WAIT_SYSREF;
        ST_WAIT_SYSREF: if (sysref_rise)     state_d = ST_COUNT;
        ST_COUNT:       if (data_start_rise) state_d = ST_DONE;
        ST_DONE:        state_d = ST_DONE;
        default:        state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // cnt_now is the offset of the current cycle; cnt_q holds the previous cycle's offset.
  always_comb begin
    cnt_now = cnt_q;
    if (sysref_rise)           cnt_now = '0;
    else if (cnt_q != CNT_MAX) cnt_now = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        cnt_q <= '0;
    else if (state_q == ST_WAIT_SYSREF) cnt_q <= '0;
    else if (state_q == ST_COUNT)       cnt_q <= cnt_now;
  end

  assign ev_hit = (state_q == ST_COUNT) && (|trig_rise);
  assign arm    = (state_q == ST_IDLE) && enable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ev_valid <= 1'b0;
      ev_trig  <= '0;
      ev_cnt   <= '0;
      ev_ctrl  <= '0;
      overflow <= 1'b0;
    end else begin
      if (ev_hit && (!ev_valid || ev_ready)) begin
        ev_valid <= 1'b1;
        ev_trig  <= trig_rise;
        ev_cnt   <= cnt_now;
        ev_ctrl  <= ctrl_in;
      end else if (ev_valid && ev_ready) begin
        ev_valid <= 1'b0;
      end

      if (arm)                                   overflow <= 1'b0;
      else if (ev_hit && ev_valid && !ev_ready)  overflow <= 1'b1;
    end
  end

  // Status flops are loaded from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_d == ST_WAIT_SYSREF) || (state_d == ST_COUNT);
      done <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_rx_fsrc_seq_capture.sv
// Directed plus randomized bench for rx_fsrc_seq_capture against a behavioural model.
module tb_rx_fsrc_seq_capture;

  localparam int CW      = 40;
  localparam int NW      = 4;
  localparam int NT      = 4;
  localparam int CNT_MAX = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable, sysref, data_start, ev_ready;
  logic [NT-1:0] trig_in;
  logic [CW-1:0] ctrl_in;
  logic          ev_valid, overflow, busy, done;
  logic [NT-1:0] ev_trig;
  logic [NW-1:0] ev_cnt;
  logic [CW-1:0] ev_ctrl;

  int n_checks = 0;
  int n_errors = 0;

  rx_fsrc_seq_capture #(
    .CTRL_WIDTH(CW), .COUNTER_WIDTH(NW), .NUM_TRIG(NT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sysref(sysref),
    .trig_in(trig_in), .data_start(data_start), .ctrl_in(ctrl_in),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_trig(ev_trig),
    .ev_cnt(ev_cnt), .ev_ctrl(ev_ctrl), .overflow(overflow),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: phase 0 off, 1 armed, 2 counting, 3 finished.
  int            m_phase;
  int            m_since;
  bit            m_valid, m_ovf;
  logic [NT-1:0] m_trig;
  int            m_cnt;
  logic [CW-1:0] m_ctrl;
  bit            p_sr, p_ds;
  logic [NT-1:0] p_tr;
  logic [CW-1:0] last_ctrl;

  function automatic void model_reset();
    m_phase = 0; m_since = 0; m_valid = 0; m_ovf = 0;
    m_trig = '0; m_cnt = 0; m_ctrl = '0;
    p_sr = 0; p_ds = 0; p_tr = '0;
  endfunction

  function automatic void model_step();
    bit            sr_r, ds_r, hit;
    logic [NT-1:0] tr_r;
    sr_r = sysref && !p_sr;
    ds_r = data_start && !p_ds;
    tr_r = trig_in & ~p_tr;
    hit  = (m_phase == 2) && (tr_r != '0);
    // Cycles elapsed since the most recent sysref rising edge.
    if (sr_r)                m_since = 0;
    else if (m_since < 1000) m_since = m_since + 1;
    if (hit) begin
      if (!m_valid || ev_ready) begin
        m_valid = 1;
        m_trig  = tr_r;
        m_cnt   = (m_since > CNT_MAX) ? CNT_MAX : m_since;
        m_ctrl  = ctrl_in;
      end else begin
        m_ovf = 1;
      end
    end else if (m_valid && ev_ready) begin
      m_valid = 0;
    end
    if (m_phase == 0 && enable) m_ovf = 0;
    if (!enable)                      m_phase = 0;
    else if (m_phase == 0)            m_phase = 1;
    else if (m_phase == 1 && sr_r)    m_phase = 2;
    else if (m_phase == 2 && ds_r)    m_phase = 3;
    p_sr = sysref; p_ds = data_start; p_tr = trig_in;
  endfunction

  task automatic compare_outputs();
    check("ev_valid", ev_valid, m_valid);
    if (m_valid) begin
      check("ev_trig", ev_trig, m_trig);
      check("ev_cnt", ev_cnt, m_cnt);
      check("ev_ctrl", ev_ctrl, m_ctrl);
    end
    check("overflow", overflow, m_ovf);
    check("busy", busy, (m_phase == 1) || (m_phase == 2));
    check("done", done, m_phase == 3);
  endtask

  task automatic tick(input bit en, input bit sr, input logic [NT-1:0] tr,
                      input bit ds, input bit rdy);
    enable     = en;
    sysref     = sr;
    trig_in    = tr;
    data_start = ds;
    ev_ready   = rdy;
    ctrl_in    = CW'({$urandom(), $urandom()});
    last_ctrl  = ctrl_in;
    model_step();
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  initial begin
    logic [CW-1:0] saved;
    bit            sr_v, ds_v;

    reset = 1'b1; enable = 0; sysref = 0; data_start = 0; ev_ready = 0;
    trig_in = '0; ctrl_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_outputs();
    check("rst_ev_cnt", ev_cnt, 0);
    check("rst_ev_ctrl", ev_ctrl, 0);
    reset = 1'b0;

    // Basic capture: sysref at t0, trigger at t0+3.
    tick(1, 0, 4'b0000, 0, 1);
    check("arm_busy", busy, 1);
    tick(1, 1, 4'b0000, 0, 1);
    tick(1, 1, 4'b0000, 0, 1);
    tick(1, 1, 4'b0000, 0, 1);
    tick(1, 1, 4'b0001, 0, 1);
    saved = last_ctrl;
    check("basic_valid", ev_valid, 1);
    check("basic_trig", ev_trig, 4'b0001);
    check("basic_cnt", ev_cnt, 3);
    check("basic_ctrl", ev_ctrl, saved);
    tick(1, 1, 4'b0001, 0, 1);
    check("basic_pulse", ev_valid, 0);

    // Accept and load in the same cycle.
    tick(1, 1, 4'b0000, 0, 0);
    tick(1, 1, 4'b0010, 0, 0);
    check("al_first", ev_trig, 4'b0010);
    tick(1, 1, 4'b1000, 0, 1);
    check("al_valid", ev_valid, 1);
    check("al_trig", ev_trig, 4'b1000);
    check("al_ovf", overflow, 0);
    tick(1, 1, 4'b1000, 0, 1);

    // Backpressure: second event dropped, overflow set.
    tick(1, 1, 4'b0100, 0, 0);
    tick(1, 1, 4'b0000, 0, 0);
    tick(1, 1, 4'b0001, 0, 0);
    check("bp_hold", ev_trig, 4'b0100);
    check("bp_ovf", overflow, 1);
    tick(1, 1, 4'b0000, 0, 1);
    check("bp_accept", ev_valid, 0);
    check("bp_sticky", overflow, 1);

    // Coincidence with sysref, then saturation.
    tick(1, 0, 4'b0000, 0, 1);
    tick(1, 1, 4'b0110, 0, 1);
    check("coin_cnt", ev_cnt, 0);
    check("coin_trig", ev_trig, 4'b0110);
    repeat (19) tick(1, 1, 4'b0000, 0, 1);
    tick(1, 1, 4'b0001, 0, 1);
    check("sat_cnt", ev_cnt, CNT_MAX);

    // Ignore before sysref, finish on data_start.
    tick(0, 0, 4'b0000, 0, 1);
    check("idle_busy", busy, 0);
    tick(1, 0, 4'b0000, 0, 1);
    check("rearm_ovf", overflow, 0);
    tick(1, 0, 4'b0001, 0, 1);
    check("wait_ignore", ev_valid, 0);
    tick(1, 1, 4'b0000, 0, 1);
    tick(1, 1, 4'b0010, 1, 1);
    check("ds_capture", ev_trig, 4'b0010);
    check("ds_done", done, 1);
    check("ds_busy", busy, 0);
    tick(1, 1, 4'b0000, 1, 1);
    tick(1, 1, 4'b0100, 1, 1);
    check("done_ignore", ev_valid, 0);

    // Abort with a pending record, then asynchronous reset.
    tick(0, 0, 4'b0000, 0, 1);
    tick(1, 0, 4'b0000, 0, 0);
    tick(1, 1, 4'b0000, 0, 0);
    tick(1, 1, 4'b0001, 0, 0);
    tick(1, 1, 4'b0000, 0, 0);
    tick(1, 1, 4'b0010, 0, 0);
    tick(0, 1, 4'b0000, 0, 0);
    check("abort_busy", busy, 0);
    check("abort_keep", ev_valid, 1);
    tick(0, 1, 4'b0000, 0, 0);
    check("abort_trig", ev_trig, 4'b0001);
    #3 reset = 1'b1;
    #1;
    check("ar_valid", ev_valid, 0);
    check("ar_trig", ev_trig, 0);
    check("ar_cnt", ev_cnt, 0);
    check("ar_ctrl", ev_ctrl, 0);
    check("ar_ovf", overflow, 0);
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      sr_v = ($urandom_range(0, 7) == 0) ? !sysref : sysref;
      ds_v = ($urandom_range(0, 39) == 0) ? !data_start : data_start;
      tick($urandom_range(0, 31) != 0, sr_v, NT'($urandom_range(0, 15)),
           ds_v, $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rx_fsrc_seq_capture.md
RX_FSRC_SEQ_CAPTURE -- requirements
Module: rx_fsrc_seq_capture

Interface
REQ-001 SHALL have parameter CTRL_WIDTH, default 40: width of the captured control word.
REQ-002 SHALL have parameter COUNTER_WIDTH, default 4: width of the sysref-relative cycle counter.
REQ-003 SHALL have parameter NUM_TRIG, default 4: number of trigger lines.
REQ-004 SHALL have port clk  input  1: single clock for all logic.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port enable  input  1: arms capture while high.
REQ-007 SHALL have port sysref  input  1: alignment reference; rising edges are used.
REQ-008 SHALL have port trig_in  input  NUM_TRIG: trigger lines from the FSRC sequencer; rising edges are used.
REQ-009 SHALL have port data_start  input  1: end-of-sequence marker; rising edge is used.
REQ-010 SHALL have port ctrl_in  input  CTRL_WIDTH: control word sampled with each event.
REQ-011 SHALL have port ev_valid  output  1: an event record is pending.
REQ-012 SHALL have port ev_ready  input  1: the consumer accepts the pending record.
REQ-013 SHALL have port ev_trig  output  NUM_TRIG: mask of the trigger lines that rose.
REQ-014 SHALL have port ev_cnt  output  COUNTER_WIDTH: cycle offset of the event from the last sysref edge.
REQ-015 SHALL have port ev_ctrl  output  CTRL_WIDTH: ctrl_in value at the event.
REQ-016 SHALL have ports overflow, busy and done  output  1 each: sticky event-dropped flag, capture active, sequence finished.

Function
REQ-017 SHALL register sysref, trig_in and data_start once; rise = input & ~registered copy, evaluated in the same cycle.
REQ-018 SHALL implement the FSM IDLE -> WAIT_SYSREF (enable=1) -> COUNT (sysref rise) -> DONE (data_start rise).
REQ-019 SHALL return from any state to IDLE on the cycle after enable=0; a pending record is retained until accepted.
REQ-020 SHALL clear overflow on the IDLE -> WAIT_SYSREF transition.
REQ-021 SHALL, in COUNT: set cnt to 0 on a sysref rise, otherwise increment cnt, saturating at 2^COUNTER_WIDTH-1.
REQ-022 SHALL, in COUNT only, treat any nonzero trig rise mask as an event, with one record per cycle carrying all bits that rose.
REQ-023 SHALL capture ev_cnt as 0 when a trig rise coincides with a sysref rise, otherwise as the current cnt.
REQ-024 SHALL assert ev_valid with the record on the cycle after the event (latency 1).
REQ-025 SHALL keep ev_valid and the payload stable until ev_valid & ev_ready.
REQ-026 SHALL deassert ev_valid on acceptance unless a new event occurs in the same cycle; in that case it loads the new record with no overflow.
REQ-027 SHALL, on an event while ev_valid=1 and ev_ready=0, drop the event, hold the old record and set overflow.
REQ-028 SHALL ignore trig rises in IDLE, WAIT_SYSREF and DONE.
REQ-029 SHALL still capture a trig rise that coincides with the data_start rise in COUNT.
REQ-030 SHALL drive busy=1 in WAIT_SYSREF and COUNT, and done=1 in DONE; both are registered from the state.

Reset
REQ-031 SHALL, while reset is high, force state=IDLE, cnt=0, registered inputs=0, ev_valid=0, ev_trig/ev_cnt/ev_ctrl=0 and overflow/busy/done=0.
REQ-032 SHALL, on reset asserted mid-operation, discard the pending record and overflow asynchronously.

Structure
REQ-033 SHALL place the FSM state enum and default parameter constants in shared package axi_fsrc_pkg.
REQ-034 SHALL use one sub-module, fsrc_edge_detect (parameterised width, register plus rise output), instantiated for sysref, trig_in and data_start.
REQ-035 SHALL need no AXI; register-map integration belongs to the wrapping axi_fsrc core.

Verification
REQ-036 Test basic: enable=1, sysref rises at t0, trig_in=4'b0001 rises at t0+3, ev_ready=1 -> ev_valid pulses one cycle at t0+4 with ev_trig=0001, ev_cnt=3, ev_ctrl=ctrl_in at t0+3.
REQ-037 Test backpressure: ev_ready=0, two events 2 cycles apart -> first record held, overflow=1; assert ev_ready -> first record accepted, ev_valid=0.
REQ-038 Test accept-and-load: ev_valid=1, ev_ready=1 and a new trig rise in the same cycle -> new record presented next cycle, overflow stays 0.
REQ-039 Test coincidence and saturation: trig 4'b0110 with sysref rise -> ev_cnt=0, ev_trig=0110; trig 20 cycles after sysref -> ev_cnt=15.
REQ-040 Test ignore and done: trig rise before sysref produces no record; data_start rise -> done=1, busy=0; later trigs are ignored.
REQ-041 Test abort: enable=0 in COUNT -> IDLE next cycle and pending record kept; reset asserted -> all outputs 0 immediately.
